// File: rtl/wifi_tx_frame_scheduler.sv
// Round-robin arbiter that lends the WiFi TX chain to one of two frame
// requesters at a time, streams its words on chain read pulses, then enforces the gap.
module wifi_tx_frame_scheduler #(
    parameter int DATA_WIDTH  = 32,
    parameter int IFS_CYC     = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] size0,
    input  logic [DATA_WIDTH-1:0] size1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rd0,
    output logic                  rd1,
    output logic [DATA_WIDTH-1:0] tx_data_size,
    output logic [DATA_WIDTH-1:0] tx_data_in,
    output logic                  tx_valid_in,
    input  logic                  tx_start_rd,
    input  logic                  tx_done,
    output logic                  tx_clear_irq,
    output logic                  busy,
    output logic                  owner,
    output logic                  frame_done,
    output logic                  err_timeout
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(IFS_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, GRANT, SEND, WAIT_DONE, CLEAR, GAP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  gsel;
    logic                  last_owner;
    logic                  owner_q;
    logic                  rd_q;
    logic                  valid_q;
    logic                  to_q;
    logic [DATA_WIDTH-1:0] size_q;
    logic [DATA_WIDTH-1:0] wcnt;
    logic [TW-1:0]         tcnt;
    logic [GW-1:0]         gcnt;
    logic                  pick;
    logic                  issue;
    logic                  in_frame;
    logic                  to_hit;
    logic [DATA_WIDTH-1:0] cur_size;

    assign pick     = (req0 && req1) ? ~last_owner : req1;
    assign cur_size = gsel ? size1 : size0;
    assign in_frame = (state == SEND) || (state == WAIT_DONE);
    assign to_hit   = in_frame && (tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) state_nxt = GRANT;
            end
            GRANT: begin
                state_nxt = (cur_size == '0) ? CLEAR : SEND;
            end
            SEND: begin
                if (to_hit) begin
                    state_nxt = CLEAR;
                end else begin
                    issue = tx_start_rd && (wcnt < size_q);
                    // leave only once the last read strobe has gone out
                    if (wcnt == size_q && !rd_q) state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (to_hit || tx_done) state_nxt = CLEAR;
            end
            CLEAR: begin
                state_nxt = GAP;
            end
            GAP: begin
                if (gcnt == GW'(IFS_CYC - 1)) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gsel       <= 1'b0;
            last_owner <= 1'b1;
            owner_q    <= 1'b0;
            size_q     <= '0;
            wcnt       <= '0;
            tcnt       <= '0;
            gcnt       <= '0;
            rd_q       <= 1'b0;
            valid_q    <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            rd_q    <= issue;
            valid_q <= rd_q;
            if (state == IDLE) gsel <= pick;
            if (state == GRANT) begin
                owner_q    <= gsel;
                last_owner <= gsel;
                size_q     <= cur_size;
                wcnt       <= '0;
                tcnt       <= '0;
            end
            if (issue) wcnt <= wcnt + DATA_WIDTH'(1);
            if (in_frame) tcnt <= tcnt + TW'(1);
            if (state_nxt == CLEAR) to_q <= to_hit;
            if (state == CLEAR) begin
                gcnt <= '0;
            end else if (state == GAP) begin
                gcnt <= gcnt + GW'(1);
            end
        end
    end

    assign gnt0         = (state == GRANT) && !gsel;
    assign gnt1         = (state == GRANT) && gsel;
    assign rd0          = rd_q && !owner_q;
    assign rd1          = rd_q && owner_q;
    assign tx_valid_in  = valid_q;
    assign tx_data_in   = valid_q ? (owner_q ? data1 : data0) : '0;
    assign tx_data_size = size_q;
    assign owner        = owner_q;
    assign busy         = (state != IDLE);
    assign tx_clear_irq = (state == CLEAR);
    assign frame_done   = (state == CLEAR) && !to_q;
    assign err_timeout  = (state == CLEAR) && to_q;

endmodule

// File: tb/tb_wifi_tx_frame_scheduler.sv
// Bench for wifi_tx_frame_scheduler: frame table, timeout/reset corners,
// then random traffic against a transaction-level model.
module tb_wifi_tx_frame_scheduler;
    localparam int DW  = 32;
    localparam int IFS = 4;
    localparam int TO  = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, tx_start_rd, tx_done;
    logic [DW-1:0] size0, size1, data0, data1;
    logic          gnt0, gnt1, rd0, rd1, tx_valid_in, tx_clear_irq;
    logic          busy, owner, frame_done, err_timeout;
    logic [DW-1:0] tx_data_size, tx_data_in;

    wifi_tx_frame_scheduler #(
        .DATA_WIDTH(DW), .IFS_CYC(IFS), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .size0(size0), .size1(size1),
        .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rd0(rd0), .rd1(rd1),
        .tx_data_size(tx_data_size),
        .tx_data_in(tx_data_in),
        .tx_valid_in(tx_valid_in),
        .tx_start_rd(tx_start_rd),
        .tx_done(tx_done),
        .tx_clear_irq(tx_clear_irq),
        .busy(busy), .owner(owner),
        .frame_done(frame_done),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r0;
        bit r1;
        int s0;
        int s1;
        int period;
        int np;
        bit exp_owner;
        int exp_words;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int seq0 = 0;
    int seq1 = 0;
    logic          s_gnt0, s_gnt1, s_rd0, s_rd1, s_valid, s_clear;
    logic          s_busy, s_owner, s_done, s_to;
    logic [DW-1:0] s_data, s_size;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int x, input int k);
        return 32'hC0DE_0000 | 32'(x << 12) | 32'(k);
    endfunction

    // sample outputs at negedge, then requesters answer their read strobes
    task automatic tick();
        @(negedge clk);
        s_gnt0 = gnt0;  s_gnt1 = gnt1;
        s_rd0 = rd0;  s_rd1 = rd1;
        s_valid = tx_valid_in;  s_data = tx_data_in;
        s_clear = tx_clear_irq;  s_busy = busy;
        s_owner = owner;  s_done = frame_done;
        s_to = err_timeout;  s_size = tx_data_size;
        if (s_gnt0) seq0 = 0;
        if (s_gnt1) seq1 = 0;
        if (s_rd0) begin data0 = word(0, seq0); seq0++; end
        if (s_rd1) begin data1 = word(1, seq1); seq1++; end
    endtask

    task automatic wait_gnt(output bit got);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (s_gnt0 || s_gnt1) got = 1'b1;
        end
        chk("grant_seen", 32'(got), 32'd1);
    endtask

    task automatic run_frame(input vec_t v);
        bit got;
        int pulses, last_p, vcnt, rdcnt, clr, fd, eto, busyc;
        logic [DW-1:0] esz;
        if (v.r0) begin req0 = 1'b1; size0 = DW'(v.s0); end
        if (v.r1) begin req1 = 1'b1; size1 = DW'(v.s1); end
        wait_gnt(got);
        if (!got) return;
        chk("gnt_owner", 32'(s_gnt1), 32'(v.exp_owner));
        chk("gnt_onehot", 32'(s_gnt0 & s_gnt1), 32'd0);
        esz = s_gnt1 ? size1 : size0;
        if (s_gnt0) req0 = 1'b0; else req1 = 1'b0;
        {pulses, last_p, vcnt, rdcnt, clr, fd, eto} = '0;
        busyc = 1;
        for (int t = 1; t < 200; t++) begin
            tick();
            if (!s_busy) break;
            busyc++;
            if (t == 1) chk("tx_data_size", s_size, esz);
            if (s_rd0 || s_rd1) begin
                rdcnt++;
                chk("rd_owner", 32'(s_rd1), 32'(v.exp_owner));
            end
            if (s_valid) begin
                chk("tx_data_in", s_data, word(int'(v.exp_owner), vcnt));
                vcnt++;
            end
            clr += int'(s_clear);
            fd  += int'(s_done);
            eto += int'(s_to);
            tx_start_rd = (pulses < v.np) && ((t - 1) % v.period == 0);
            if (tx_start_rd) begin pulses++; last_p = t; end
            tx_done = (pulses == v.np) && (t >= last_p + 3) && (clr == 0);
        end
        tx_start_rd = 1'b0;
        tx_done = 1'b0;
        chk("frame_end", 32'(s_busy), 32'd0);
        chk("rd_count", 32'(rdcnt), 32'(v.exp_words));
        chk("valid_count", 32'(vcnt), 32'(v.exp_words));
        chk("clear_count", 32'(clr), 32'd1);
        chk("done_count", 32'(fd), 32'd1);
        chk("timeout_count", 32'(eto), 32'd0);
        chk("owner_out", 32'(s_owner), 32'(v.exp_owner));
        if (v.exp_words == 0) chk("busy_len", 32'(busyc), 32'(2 + IFS));
    endtask

    task automatic run_timeout(input int done_at);
        bit got;
        int to_t, fd, clr;
        req0 = 1'b1;
        size0 = 32'd2;
        wait_gnt(got);
        if (!got) return;
        req0 = 1'b0;
        to_t = -1; fd = 0; clr = 0;
        for (int t = 1; t < 60; t++) begin
            tick();
            if (!s_busy) break;
            if (s_to && to_t < 0) begin
                to_t = t;
                chk("to_clear_irq", 32'(s_clear), 32'd1);
            end
            fd  += int'(s_done);
            clr += int'(s_clear);
            tx_start_rd = (t == 1) || (t == 3);
            tx_done = (t == done_at);
        end
        tx_start_rd = 1'b0;
        tx_done = 1'b0;
        chk("to_cycle", 32'(to_t), 32'(TO + 1));
        chk("to_no_done", 32'(fd), 32'd0);
        chk("to_clear_count", 32'(clr), 32'd1);
    endtask

    task automatic run_reset_mid();
        bit got;
        int rdn;
        req0 = 1'b1;
        size0 = 32'd4;
        wait_gnt(got);
        if (!got) return;
        req0 = 1'b0;
        rdn = 0;
        for (int t = 0; t < 20 && rdn < 2; t++) begin
            tick();
            if (s_rd0) rdn++;
            tx_start_rd = (rdn < 2);
        end
        chk("rst_mid_word2", 32'(rdn), 32'd2);
        reset = 1'b1;
        tx_start_rd = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rd", 32'({rd1, rd0}), 32'd0);
        chk("rst_mid_valid", 32'(tx_valid_in), 32'd0);
        chk("rst_mid_size", tx_data_size, 32'd0);
        chk("rst_mid_data", tx_data_in, 32'd0);
        tick();
        reset = 1'b0;
    endtask

    task automatic run_random(input int ncyc);
        bit m_last, own, open, pa1, pa2, acc_now;
        int acc, vcnt, since, last_clr, frames;
        int size_cur;
        bit in_frame, exp1;
        m_last = 1'b0;
        {own, open, pa1, pa2, in_frame} = '0;
        {acc, vcnt, since, size_cur, frames} = '0;
        last_clr = -100;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            since++;
            chk("rnd_rd", 32'({s_rd1, s_rd0}), pa1 ? (own ? 32'd2 : 32'd1) : 32'd0);
            chk("rnd_valid", 32'(s_valid), 32'(pa2));
            if (s_valid) begin
                chk("rnd_data", s_data, word(int'(own), vcnt));
                vcnt++;
            end
            if (s_to) chk("rnd_timeout", 32'(s_to), 32'd0);
            pa2 = pa1;
            if (s_gnt0 || s_gnt1) begin
                exp1 = (req0 && req1) ? ~m_last : req1;
                chk("rnd_rr", 32'({s_gnt1, s_gnt0}), exp1 ? 32'd2 : 32'd1);
                chk("rnd_ifs", 32'(c - last_clr >= IFS + 2), 32'd1);
                own = exp1;
                m_last = exp1;
                size_cur = exp1 ? int'(size1) : int'(size0);
                if (exp1) req1 = 1'b0; else req0 = 1'b0;
                {acc, vcnt, since} = '0;
                in_frame = 1'b1;
                frames++;
            end
            if (s_clear) begin
                chk("rnd_fdone", 32'(s_done), 32'd1);
                chk("rnd_words", 32'(vcnt), 32'(size_cur));
                last_clr = c;
                open = 1'b0;
                in_frame = 1'b0;
            end
            tx_start_rd = (open && acc < size_cur && since > 6) ||
                          ($urandom % 4 != 0);
            acc_now = open && tx_start_rd && (acc < size_cur);
            if (acc_now) acc++;
            pa1 = acc_now;
            if (s_gnt0 || s_gnt1) open = 1'b1;
            tx_done = in_frame && (vcnt == size_cur);
            if (!(s_gnt0 || s_gnt1)) begin
                if (!req0 && $urandom % 6 == 0) begin
                    req0 = 1'b1;
                    size0 = DW'($urandom_range(0, 3));
                end
                if (!req1 && $urandom % 6 == 0) begin
                    req1 = 1'b1;
                    size1 = DW'($urandom_range(0, 3));
                end
            end
        end
        chk("rnd_frames", 32'(frames >= 20), 32'd1);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 2, 3, 1, 2, 1'b0, 2};
        tbl[1] = '{1'b0, 1'b0, 0, 0, 2, 3, 1'b1, 3};
        tbl[2] = '{1'b1, 1'b1, 1, 1, 1, 1, 1'b0, 1};
        tbl[3] = '{1'b0, 1'b0, 0, 0, 1, 1, 1'b1, 1};
        tbl[4] = '{1'b1, 1'b0, 4, 0, 3, 4, 1'b0, 4};
        tbl[5] = '{1'b0, 1'b1, 0, 0, 1, 0, 1'b1, 0};
        tbl[6] = '{1'b1, 1'b0, 2, 0, 1, 7, 1'b0, 2};

        reset = 1'b1;
        {req0, req1, tx_start_rd, tx_done} = '0;
        {size0, size1, data0, data1} = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_gnt", 32'({s_gnt1, s_gnt0}), 32'd0);
        chk("rst_rd", 32'({s_rd1, s_rd0}), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_size", s_size, 32'd0);
        chk("rst_flags", 32'({s_clear, s_done, s_to, s_owner}), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_frame(tbl[i]);
        run_timeout(-1);
        run_timeout(TO);
        run_reset_mid();
        run_frame('{1'b1, 1'b0, 4, 0, 1, 4, 1'b0, 4});
        run_random(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
